nes_pad_responder: RTL and testbench
====================================

Name: nes_pad_responder

Overview:
- Controller-side end of the NES serial pad protocol: emulates the pad's 4021 parallel-in/serial-out register for an external console or host.
- Samples eight button inputs while the console holds latch high, then shifts one bit per console clock onto the data line in order A, B, Select, Start, Up, Down, Left, Right.
- Console latch and clock are asynchronous to the local clock and are oversampled by it.

Parameters:
- ACTIVE_LOW_DATA, 1, 1 = pressed button drives nes_data low and idle/fill level is high; 0 = pressed drives high and idle is low.
- TURBO_FRAMES, 4, number of latch frames per turbo toggle half-period (used only with NES_TURBO_EN).

Ports:
- clk  in  1  local system clock; must be ≥ 8× the nes_clk frequency.
- reset  in  1  asynchronous, active-low reset.
- nes_latch  in  1  console latch, asynchronous, active-high.
- nes_clk  in  1  console shift clock, asynchronous; shift on rising edge.
- a, b, select, start, up, down, left, right  in  1 each  button state, 1 = pressed; bit index order 0..7.
- turbo_a, turbo_b  in  1 each  turbo enables; ignored unless NES_TURBO_EN is defined.
- nes_data  out  1  serial data to console.
- busy  out  1  high in LOAD or SHIFT.
- frame_done  out  1  one-cycle pulse when the 8th bit has been shifted out.

Behaviour:
- Synchronisers: each of nes_latch and nes_clk passes through a 2-flop synchroniser, then a third register for edge detection.
- Latency: nes_data updates on the 3rd clk rising edge after a pin edge.
- State machine:
  - IDLE → LOAD when synced latch = 1.
  - LOAD: shreg <= buttons (mapped per ACTIVE_LOW_DATA) every cycle while latch = 1, so the last sample before latch fall is kept. bit_cnt <= 0. nes_data = shreg[0], updated live.
  - LOAD → SHIFT on synced latch falling edge. nes_data holds bit 0 (A).
  - SHIFT: on each synced nes_clk rising edge, shreg <= {fill, shreg[7:1]} and bit_cnt++. nes_data = shreg[0].
  - SHIFT → DONE when bit_cnt reaches 7 and an nes_clk rising edge arrives. At that point frame_done pulses for 1 cycle and nes_data = fill.
  - DONE: nes_data = fill. Further nes_clk edges are ignored and keep the fill level.
  - DONE → LOAD on synced latch = 1.
- fill = 1 if ACTIVE_LOW_DATA, else 0. In IDLE, nes_data = fill.
- Boundary conditions:
  - Synced latch = 1 in any state (including mid-SHIFT): go to LOAD at once, reload shreg, clear bit_cnt. The current frame is abandoned with no frame_done.
  - Latch high and nes_clk rising edge in the same cycle: latch wins, no shift.
  - nes_clk edges while in LOAD or IDLE: ignored.
  - bit_cnt is 4 bits and saturates at 8; it never wraps.
- Reset (asserted at any time, including mid-frame):
  - state = IDLE, shreg = all fill, bit_cnt = 0, synchronisers = 0.
  - Outputs: nes_data = fill, busy = 0, frame_done = 0.
- busy = (state == LOAD || state == SHIFT), registered.

Optional Feature:
- Macro: NES_TURBO_EN.
- When defined:
  - A 1-bit turbo phase register toggles every TURBO_FRAMES latch falling edges. Its frame counter is cleared by reset.
  - When turbo_a = 1, the loaded A bit = a AND phase. turbo_b applies the same rule to B.
  - Phase resets to 1.
- When undefined:
  - No phase or counter logic is present; turbo_a and turbo_b are unconnected and loads use the raw buttons.

Test Plan:
- Reset, ACTIVE_LOW_DATA=1, no latch → nes_data = 1, busy = 0, frame_done = 0. Pulse nes_clk 5× → nes_data stays 1.
- Buttons a=1, start=1, right=1; latch pulse 12 µs then 8 nes_clk pulses at 83 kHz (clk = 1 MHz or faster) → sampled bits 0,1,1,0,1,1,1,0. frame_done pulses once after the 8th edge; a 9th edge gives 1.
- Change buttons to b=1 during SHIFT after bit 2 → remaining bits still reflect the original load. The next latch frame shows B at bit 1 = 0.
- Assert latch after 4 shifts → nes_data returns to bit 0 within 3 clk; no frame_done; a full 8-bit frame follows correctly.
- Assert reset mid-SHIFT (after bit 5) → nes_data = 1 and busy = 0 asynchronously. The next latch frame is correct.
- With NES_TURBO_EN, TURBO_FRAMES=2, a=1, turbo_a=1, 8 frames → A bit reads pressed/pressed/released/released/pressed/pressed/released/released.

Source files
------------

// File: rtl/nes_pad_responder.sv
// Pad-side NES serial responder that emulates the 4021 shift register for a console or host.
// Define NES_TURBO_EN to build the turbo auto-fire gating on the A and B buttons.
module nes_pad_responder #(
    parameter int ACTIVE_LOW_DATA = 1,
    parameter int TURBO_FRAMES    = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       nes_latch,
    input  logic       nes_clk,
    input  logic       a,
    input  logic       b,
    input  logic       select,
    input  logic       start,
    input  logic       up,
    input  logic       down,
    input  logic       left,
    input  logic       right,
    input  logic       turbo_a,
    input  logic       turbo_b,
    output logic       nes_data,
    output logic       busy,
    output logic       frame_done,
    output logic [1:0] dbg_state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic FILL = (ACTIVE_LOW_DATA != 0) ? 1'b1 : 1'b0;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [7:0] r_shreg;
    logic [7:0] w_shreg_nxt;
    logic [3:0] r_bit_cnt;
    logic [3:0] w_cnt_nxt;
    logic       r_busy;
    logic       r_frame_done;
    logic       w_done_nxt;
    logic [2:0] r_latch_sync;
    logic [2:0] r_clk_sync;
    logic       w_latch;
    logic       w_latch_fall;
    logic       w_clk_rise;
    logic [7:0] w_buttons;
    logic [7:0] w_load_val;

    // Stages 0..1 synchronise the console pins; stage 2 is the previous value for edge detection.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_latch_sync <= 3'b000;
            r_clk_sync   <= 3'b000;
        end else begin
            r_latch_sync <= {r_latch_sync[1:0], nes_latch};
            r_clk_sync   <= {r_clk_sync[1:0], nes_clk};
        end
    end

    assign w_latch      = r_latch_sync[1];
    assign w_latch_fall = ~r_latch_sync[1] & r_latch_sync[2];
    assign w_clk_rise   = r_clk_sync[1] & ~r_clk_sync[2];

`ifdef NES_TURBO_EN
    localparam int TW = (TURBO_FRAMES > 1) ? $clog2(TURBO_FRAMES) : 1;

    logic [TW-1:0] r_turbo_cnt;
    logic          r_phase;

    // Phase flips once every TURBO_FRAMES completed latch pulses.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_turbo_cnt <= '0;
            r_phase     <= 1'b1;
        end else if (w_latch_fall) begin
            if (r_turbo_cnt == TW'(TURBO_FRAMES - 1)) begin
                r_turbo_cnt <= '0;
                r_phase     <= ~r_phase;
            end else begin
                r_turbo_cnt <= r_turbo_cnt + 1'b1;
            end
        end
    end

    assign w_buttons = {right, left, down, up, start, select,
                        turbo_b ? (b & r_phase) : b,
                        turbo_a ? (a & r_phase) : a};
`else
    logic w_unused_turbo;
    assign w_unused_turbo = turbo_a | turbo_b;
    assign w_buttons      = {right, left, down, up, start, select, b, a};
`endif

    assign w_load_val = w_buttons ^ {8{FILL}};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= IDLE;
            r_shreg      <= {8{FILL}};
            r_bit_cnt    <= 4'd0;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_shreg      <= w_shreg_nxt;
            r_bit_cnt    <= w_cnt_nxt;
            r_busy       <= (w_state_nxt == LOAD) || (w_state_nxt == SHIFT);
            r_frame_done <= w_done_nxt;
        end
    end

    // A high latch overrides everything, including a coincident clock edge.
    always_comb begin
        w_state_nxt = r_state;
        w_shreg_nxt = r_shreg;
        w_cnt_nxt   = r_bit_cnt;
        w_done_nxt  = 1'b0;
        if (w_latch) begin
            w_state_nxt = LOAD;
            w_shreg_nxt = w_load_val;
            w_cnt_nxt   = 4'd0;
        end else begin
            case (r_state)
                IDLE: w_state_nxt = IDLE;
                LOAD: begin
                    if (w_latch_fall) begin
                        w_state_nxt = SHIFT;
                    end
                end
                SHIFT: begin
                    if (w_clk_rise) begin
                        w_shreg_nxt = {FILL, r_shreg[7:1]};
                        w_cnt_nxt   = (r_bit_cnt < 4'd8) ? r_bit_cnt + 4'd1 : r_bit_cnt;
                        if (r_bit_cnt == 4'd7) begin
                            w_state_nxt = DONE;
                            w_done_nxt  = 1'b1;
                        end
                    end
                end
                DONE:    w_state_nxt = DONE;
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    assign nes_data   = ((r_state == LOAD) || (r_state == SHIFT)) ? r_shreg[0] : FILL;
    assign busy       = r_busy;
    assign frame_done = r_frame_done;
    assign dbg_state  = r_state;

endmodule

// File: tb/tb_nes_pad_responder.sv
// Directed bench for nes_pad_responder: a console model drives latch/clock, a monitor
// checks {nes_data, busy, frame_done pulse count} against a queue of expected samples.
module tb_nes_pad_responder;

    logic       clk;
    logic       reset;
    logic       nes_latch;
    logic       nes_clk;
    logic       a, b, select, start, up, down, left, right;
    logic       turbo_a, turbo_b;
    logic       nes_data;
    logic       busy;
    logic       frame_done;
    logic [1:0] dbg_state;

    logic [9:0] exp_q[$];
    string      name_q[$];
    logic       smp_stb;
    int         fd_seen;
    int         vectors;
    int         miscompares;

    // Hand-computed serial images (LSB first, active-low data).
    logic [7:0] enc_p1; // a, start, right
    logic [7:0] enc_p2; // a, start, down, right
    logic [7:0] enc_p3; // a, b, start, right

    nes_pad_responder #(
        .ACTIVE_LOW_DATA(1),
        .TURBO_FRAMES   (2)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .nes_latch (nes_latch),
        .nes_clk   (nes_clk),
        .a         (a),
        .b         (b),
        .select    (select),
        .start     (start),
        .up        (up),
        .down      (down),
        .left      (left),
        .right     (right),
        .turbo_a   (turbo_a),
        .turbo_b   (turbo_b),
        .nes_data  (nes_data),
        .busy      (busy),
        .frame_done(frame_done),
        .dbg_state (dbg_state)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor / scoreboard
    always @(negedge clk) begin
        if (frame_done) fd_seen = fd_seen + 1;
        if (smp_stb) begin
            logic [9:0] exp_v;
            logic [9:0] act_v;
            string      nm;
            vectors = vectors + 1;
            act_v   = {nes_data, busy, 8'(fd_seen)};
            if (exp_q.size() == 0) begin
                miscompares = miscompares + 1;
                $display("FAIL underflow: sample with empty expected queue, got %b", act_v);
            end else begin
                exp_v = exp_q.pop_front();
                nm    = name_q.pop_front();
                if (act_v !== exp_v) begin
                    miscompares = miscompares + 1;
                    $display("FAIL %s @%0t: data/busy/fd got %b/%b/%0d expected %b/%b/%0d",
                             nm, $time, act_v[9], act_v[8], act_v[7:0],
                             exp_v[9], exp_v[8], exp_v[7:0]);
                end
            end
        end
    end

    // Driver tasks
    task automatic check_now(input logic d, input logic bz, input int fd, input string nm);
        exp_q.push_back({d, bz, 8'(fd)});
        name_q.push_back(nm);
        smp_stb = 1'b1;
        @(negedge clk);
        #1 smp_stb = 1'b0;
    endtask

    task automatic check(input logic d, input logic bz, input int fd, input string nm);
        @(posedge clk);
        #1;
        check_now(d, bz, fd, nm);
    endtask

    task automatic set_buttons(input logic [7:0] v);
        {right, left, down, up, start, select, b, a} = v;
    endtask

    task automatic clk_pulse();
        nes_clk = 1'b1;
        #100;
        nes_clk = 1'b0;
        #100;
    endtask

    task automatic do_latch();
        nes_latch = 1'b1;
        #200;
        nes_latch = 1'b0;
        #100;
    endtask

    task automatic shift_check(input logic [7:0] enc, input int from, input int to, input int fd);
        for (int i = from; i <= to; i++) begin
            clk_pulse();
            check(enc[i], 1'b1, fd, $sformatf("bit%0d", i));
        end
    endtask

    // Stimulus
    initial begin
        reset = 1'b0; nes_latch = 1'b0; nes_clk = 1'b0;
        turbo_a = 1'b0; turbo_b = 1'b0; smp_stb = 1'b0;
        fd_seen = 0; vectors = 0; miscompares = 0;
        enc_p1 = 8'b0111_0110;
        enc_p2 = 8'b0101_0110;
        enc_p3 = 8'b0111_0100;
        set_buttons(8'h00);

        repeat (3) @(posedge clk);
        #1;
        check_now(1'b1, 1'b0, 0, "in_reset");
        @(posedge clk);
        #1 reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            clk_pulse();
            check(1'b1, 1'b0, 0, "idle_clk");
        end

        // Full frame, with live load while latch is high
        set_buttons(8'b1000_1001);
        nes_latch = 1'b1;
        #100;
        check(1'b0, 1'b1, 0, "load_live_a");
        a = 1'b0;
        #100;
        check(1'b1, 1'b1, 0, "load_live_na");
        a = 1'b1;
        #100;
        nes_latch = 1'b0;
        #100;
        check(enc_p1[0], 1'b1, 0, "f1_bit0");
        shift_check(enc_p1, 1, 7, 0);
        clk_pulse();
        check(1'b1, 1'b0, 1, "f1_done");
        clk_pulse();
        check(1'b1, 1'b0, 1, "f1_ninth");

        // Buttons change mid-shift; next frame picks them up
        do_latch();
        check(enc_p1[0], 1'b1, 1, "f2_bit0");
        shift_check(enc_p1, 1, 2, 1);
        set_buttons(8'b1000_1011);
        shift_check(enc_p1, 3, 7, 1);
        clk_pulse();
        check(1'b1, 1'b0, 2, "f2_done");
        do_latch();
        check(enc_p3[0], 1'b1, 2, "f3_bit0");
        shift_check(enc_p3, 1, 7, 2);
        clk_pulse();
        check(1'b1, 1'b0, 3, "f3_done");

        // Latch re-asserted after four shifts
        set_buttons(8'b1000_1001);
        do_latch();
        check(enc_p1[0], 1'b1, 3, "f4_bit0");
        shift_check(enc_p1, 1, 4, 3);
        @(posedge clk);
        #1 nes_latch = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_now(enc_p1[0], 1'b1, 3, "abort_lat3");
        #200;
        nes_latch = 1'b0;
        #100;
        check(enc_p1[0], 1'b1, 3, "f5_bit0");
        shift_check(enc_p1, 1, 7, 3);
        clk_pulse();
        check(1'b1, 1'b0, 4, "f5_done");

        // Reset mid-shift after bit 5
        set_buttons(8'b1010_1001);
        do_latch();
        check(enc_p2[0], 1'b1, 4, "f6_bit0");
        shift_check(enc_p2, 1, 5, 4);
        @(posedge clk);
        #1 reset = 1'b0;
        check_now(1'b1, 1'b0, 4, "rst_async");
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        check(1'b1, 1'b0, 4, "rst_idle");
        do_latch();
        check(enc_p2[0], 1'b1, 4, "f7_bit0");
        shift_check(enc_p2, 1, 7, 4);
        clk_pulse();
        check(1'b1, 1'b0, 5, "f7_done");

        // Turbo on A: eight frames from a fresh reset
        @(posedge clk);
        #1 reset = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        set_buttons(8'h01);
        turbo_a = 1'b1;
        for (int k = 0; k < 8; k++) begin
            logic pressed;
`ifdef NES_TURBO_EN
            pressed = (((k / 2) % 2) == 0);
`else
            pressed = 1'b1;
`endif
            do_latch();
            check(~pressed, 1'b1, 5, $sformatf("turbo_f%0d", k));
        end
        turbo_a = 1'b0;

        repeat (10) @(posedge clk);
        if (exp_q.size() != 0) begin
            miscompares = miscompares + 1;
            $display("FAIL drain: %0d expected samples left, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
